// File: rtl/signed_alu_pipe.sv
// rtl/signed_alu_pipe.sv - signed ALU with valid/ready handshake and a multi-cycle restoring divider
module signed_alu_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_FUN,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             Arith_Flag,
  output logic             Logic_Flag,
  output logic             CMP_Flag,
  output logic             Shift_Flag,
  output logic             Ovf_Flag,
  output logic             Div0_Flag
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic [3:0]       unit_q, unit_d;
  logic             ovf_q, ovf_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_q, neg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH:0]           sum_x, dif_x;
  logic signed [2*WIDTH-1:0] prod;
  logic [SHW-1:0]           shamt;
  logic [WIDTH-1:0]         op_res, abs_a, abs_b;
  logic                     op_ovf;
  logic [WIDTH:0]           rem_sh, trial;
  logic                     accept, is_div, div0;

  always_comb begin : alu_comb
    sum_x  = {A[WIDTH-1], A} + {B[WIDTH-1], B};
    dif_x  = {A[WIDTH-1], A} - {B[WIDTH-1], B};
    prod   = $signed({{WIDTH{A[WIDTH-1]}}, A}) * $signed({{WIDTH{B[WIDTH-1]}}, B});
    shamt  = B[SHW-1:0];
    abs_a  = A[WIDTH-1] ? -A : A;
    abs_b  = B[WIDTH-1] ? -B : B;
    op_res = '0;
    op_ovf = 1'b0;
    case (ALU_FUN)
      4'h0: begin op_res = sum_x[WIDTH-1:0]; op_ovf = sum_x[WIDTH] ^ sum_x[WIDTH-1]; end
      4'h1: begin op_res = dif_x[WIDTH-1:0]; op_ovf = dif_x[WIDTH] ^ dif_x[WIDTH-1]; end
      4'h2: begin
        op_res = prod[WIDTH-1:0];
        op_ovf = (prod != {{WIDTH{prod[WIDTH-1]}}, prod[WIDTH-1:0]});
      end
      4'h3: op_res = '0;
      4'h4: op_res = A & B;
      4'h5: op_res = A | B;
      4'h6: op_res = ~(A & B);
      4'h7: op_res = ~(A | B);
      4'h8: op_res = {{(WIDTH-1){1'b0}}, (A == B)};
      4'h9: op_res = {{(WIDTH-1){1'b0}}, ($signed(A) > $signed(B))};
      4'hA: op_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'hB: op_res = {{(WIDTH-1){1'b0}}, (A != B)};
      4'hC, 4'hE: op_res = A << shamt;
      4'hD: op_res = A >> shamt;
      default: op_res = $signed(A) >>> shamt;
    endcase
  end

  // Remainder/quotient pair shifts left as one register; the dividend MSB feeds the remainder.
  always_comb begin : div_step
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvs_q};
  end

  always_comb begin : fsm_comb
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    alu_out_d   = alu_out_q;
    unit_d      = unit_q;
    ovf_d       = ovf_q;
    div0_d      = div0_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_d       = neg_q;
    cnt_d       = cnt_q;
    in_ready    = (state_q == IDLE) && (!out_valid_q || out_ready) && !rst;
    accept      = in_valid && in_ready;
    is_div      = (ALU_FUN == 4'h3);
    div0        = is_div && (B == '0);
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_div && !div0) begin
            state_d = DIV;
            rem_d   = '0;
            quo_d   = abs_a;
            dvs_d   = abs_b;
            neg_d   = A[WIDTH-1] ^ B[WIDTH-1];
            cnt_d   = '0;
          end else begin
            out_valid_d = 1'b1;
            alu_out_d   = op_res;
            unit_d      = 4'b1000 >> ALU_FUN[3:2];
            ovf_d       = op_ovf;
            div0_d      = div0;
          end
        end
      end
      DIV: begin
        rem_d = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        // Only MIN / -1 yields a positive magnitude of 2^(WIDTH-1).
        out_valid_d = 1'b1;
        alu_out_d   = neg_q ? -quo_q : quo_q;
        unit_d      = 4'b1000;
        ovf_d       = !neg_q && quo_q[WIDTH-1];
        div0_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      unit_q      <= '0;
      ovf_q       <= 1'b0;
      div0_q      <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      unit_q      <= unit_d;
      ovf_q       <= ovf_d;
      div0_q      <= div0_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_q       <= neg_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign ALU_Out    = alu_out_q;
  assign Arith_Flag = unit_q[3];
  assign Logic_Flag = unit_q[2];
  assign CMP_Flag   = unit_q[1];
  assign Shift_Flag = unit_q[0];
  assign Ovf_Flag   = ovf_q;
  assign Div0_Flag  = div0_q;

endmodule

// File: doc/signed_alu_pipe.md
SIGNED_ALU_PIPE -- requirements
Module: signed_alu_pipe

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the operand and result width in bits; legal range 4..64.
REQ-002 Parameter SHW, default $clog2(WIDTH), SHALL set the width of the shift-amount field.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 in_valid  input  1  SHALL indicate that A, B and ALU_FUN hold a request.
REQ-006 in_ready  output  1  SHALL indicate that the block accepts a request this cycle.
REQ-007 A, B  input  WIDTH each  SHALL be signed two's-complement operands.
REQ-008 ALU_FUN  input  4  SHALL select the operation, with the encoding in REQ-015.
REQ-009 out_valid  output  1  SHALL indicate that ALU_Out and the flags hold a result.
REQ-010 out_ready  input  1  SHALL indicate that the consumer accepts the result.
REQ-011 ALU_Out  output  WIDTH  SHALL be the signed result.
REQ-012 Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag  output  1 each  SHALL form a one-hot indication of the unit that produced the current result.
REQ-013 Ovf_Flag  output  1  SHALL indicate signed overflow.
REQ-014 Div0_Flag  output  1  SHALL indicate a divide-by-zero request.

Function
REQ-015 ALU_FUN encoding SHALL be:
- 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV
- 0100 AND, 0101 OR, 0110 NAND, 0111 NOR
- 1000 EQ, 1001 GT, 1010 LT, 1011 NE
- 1100 LSL, 1101 LSR, 1110 ASL, 1111 ASR
REQ-016 A request SHALL be accepted on a cycle where in_valid && in_ready; operands and function are captured on that edge.
REQ-017 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready) && !rst.
REQ-018 A result SHALL be consumed on a cycle where out_valid && out_ready; ALU_Out and all flags SHALL hold stable while out_valid && !out_ready.
REQ-019 FSM states SHALL be IDLE, DIV and DONE:
- IDLE: accepting a non-DIV request loads the output register the same edge (out_valid=1 next cycle, latency 1) and stays in IDLE.
- IDLE: accepting a DIV with B!=0 goes to DIV.
- DIV: runs WIDTH iterations of a restoring divider on magnitudes, then goes to DONE.
- DONE: loads the output register and returns to IDLE; DIV latency is therefore WIDTH+2 cycles from acceptance to out_valid.
REQ-020 A consume and a new accept in the same cycle SHALL be permitted (back-to-back, one result per cycle for non-DIV operations).
REQ-021 ADD, SUB and MUL results SHALL be truncated to the low WIDTH bits; Ovf_Flag=1 when the exact signed result does not fit in WIDTH bits, else 0.
REQ-022 DIV SHALL truncate toward zero, with the quotient sign equal to sign(A) XOR sign(B).
REQ-023 DIV with B==0 SHALL complete with latency 1: ALU_Out=0, Div0_Flag=1, Ovf_Flag=0.
REQ-024 DIV of MIN by -1 SHALL give ALU_Out=MIN and Ovf_Flag=1.
REQ-025 Logic operations SHALL be bitwise on WIDTH bits; Ovf_Flag=0.
REQ-026 Compare operations SHALL be signed; ALU_Out = 1 when true, 0 when false; Ovf_Flag=0.
REQ-027 Shift operations SHALL shift A by the amount B[SHW-1:0]:
- LSL and ASL: zero fill from the right.
- LSR: zero fill from the left.
- ASR: sign fill from the left.
- Shift amount 0: ALU_Out=A.
- Ovf_Flag=0.
REQ-028 Div0_Flag SHALL be 0 for all operations other than DIV with B==0.

Reset
REQ-029 While rst=1 at a clock edge, the block SHALL:
- return the FSM to IDLE;
- set out_valid=0, ALU_Out=0 and all six flags to 0;
- hold in_ready at 0.
REQ-030 rst asserted during DIV or DONE SHALL abort the division with no result produced; in_ready=1 on the first cycle after rst deasserts.

Verification
REQ-031 WIDTH=16, out_ready=1: ADD 32767+1 -> one cycle later ALU_Out=-32768, Arith_Flag=1, Ovf_Flag=1.
REQ-032 WIDTH=16: DIV -15/4 -> out_valid exactly 18 cycles after acceptance, ALU_Out=-3; in_ready=0 throughout the division.
REQ-033 WIDTH=16: DIV 7/0 -> ALU_Out=0, Div0_Flag=1 after 1 cycle; then DIV -32768/-1 -> ALU_Out=-32768, Ovf_Flag=1.
REQ-034 WIDTH=16: ASR -8 by 2 -> -2; LSR -8 by 2 -> 16382; LT -3 vs 2 -> ALU_Out=1, CMP_Flag=1.
REQ-035 out_ready held low for 3 cycles after an AND 8&3 result -> ALU_Out=0 and Logic_Flag=1 held stable, in_ready=0; release -> next request accepted in the same cycle.
REQ-036 rst pulsed at cycle 5 of a DIV -> no out_valid is produced; the next ADD 10+5 returns 15.
